// File: rtl/exu_issue_buffer_if.sv
// Issue-port bundle between the pipeline issue stage and an execution unit.
// The alu_sif/lsu_sif modports are the EXU (slave) view; issue is the driver view.
interface pip_exu_interface #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic [19:0]     imm20;
  logic [4:0]      opcode;
  logic [9:0]      funct;
  logic [7:0]      itag;
  logic            valid;
  logic            full;

  modport alu_sif (input data1, data2, imm20, opcode, funct, itag, valid, output full);
  modport lsu_sif (input data1, data2, imm20, opcode, funct, itag, valid, output full);
  modport issue   (output data1, data2, imm20, opcode, funct, itag, valid, input full);
endinterface

// File: rtl/exu_issue_buffer.sv
// In-order issue FIFO in front of a multi-cycle EXU, with full backpressure.
// Optional EXU_ISSUE_BYPASS_EN: forwards an incoming uop straight to the head when empty.
module exu_issue_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  pip_exu_interface.lsu_sif          exu_sif,
  input  logic                       flush_i,
  output logic                       uop_valid_o,
  input  logic                       uop_ready_i,
  output logic [XLEN-1:0]            uop_data1_o,
  output logic [XLEN-1:0]            uop_data2_o,
  output logic [19:0]                uop_imm20_o,
  output logic [4:0]                 uop_opcode_o,
  output logic [9:0]                 uop_funct_o,
  output logic [7:0]                 uop_itag_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [19:0]     imm20;
    logic [4:0]      opcode;
    logic [9:0]      funct;
    logic [7:0]      itag;
  } uop_t;

  uop_t          mem [DEPTH];
  uop_t          wr_uop;
  uop_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          bypass_take;
  logic          push;
  logic          pop;

  assign wr_uop = '{data1:  exu_sif.data1,  data2: exu_sif.data2, imm20: exu_sif.imm20,
                    opcode: exu_sif.opcode, funct: exu_sif.funct, itag:  exu_sif.itag};

  assign empty        = (count == '0);
  assign exu_sif.full = (count == CW'(DEPTH));

`ifdef EXU_ISSUE_BYPASS_EN
  // An empty buffer with a ready consumer hands the uop straight through without storing it.
  assign bypass_take = empty & exu_sif.valid & uop_ready_i & ~flush_i;
  assign uop_valid_o = ~empty | (exu_sif.valid & ~flush_i);
  assign head        = empty ? wr_uop : mem[rd_ptr];
`else
  assign bypass_take = 1'b0;
  assign uop_valid_o = ~empty;
  assign head        = mem[rd_ptr];
`endif

  assign push = exu_sif.valid & ~exu_sif.full & ~flush_i & ~bypass_take;
  assign pop  = ~empty & uop_ready_i & ~flush_i;

  // Payload storage; flush leaves contents in place, only reset clears them.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_uop;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign uop_data1_o  = head.data1;
  assign uop_data2_o  = head.data2;
  assign uop_imm20_o  = head.imm20;
  assign uop_opcode_o = head.opcode;
  assign uop_funct_o  = head.funct;
  assign uop_itag_o   = head.itag;
  assign count_o      = count;

endmodule

// File: tb/tb_exu_issue_buffer.sv
// Randomized bench for exu_issue_buffer against a queue-based reference model.
module tb_exu_issue_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  typedef struct packed {
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [19:0]     imm;
    logic [4:0]      op;
    logic [9:0]      fn;
    logic [7:0]      tag;
  } uop_t;

  logic            clk = 1'b0;
  logic            arst_i;
  logic            flush_i;
  logic            uop_valid_o;
  logic            uop_ready_i;
  logic [XLEN-1:0] uop_data1_o;
  logic [XLEN-1:0] uop_data2_o;
  logic [19:0]     uop_imm20_o;
  logic [4:0]      uop_opcode_o;
  logic [9:0]      uop_funct_o;
  logic [7:0]      uop_itag_o;
  logic [2:0]      count_o;

  int vectors = 0;
  int errors  = 0;
  uop_t q[$];
  uop_t idle_uop = '0;

  pip_exu_interface #(.XLEN(XLEN)) bus ();

  exu_issue_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i        (clk),
    .arst_i       (arst_i),
    .exu_sif      (bus),
    .flush_i      (flush_i),
    .uop_valid_o  (uop_valid_o),
    .uop_ready_i  (uop_ready_i),
    .uop_data1_o  (uop_data1_o),
    .uop_data2_o  (uop_data2_o),
    .uop_imm20_o  (uop_imm20_o),
    .uop_opcode_o (uop_opcode_o),
    .uop_funct_o  (uop_funct_o),
    .uop_itag_o   (uop_itag_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic uop_t mk(input logic [7:0] tag);
    uop_t u;
    u.tag = tag;
    u.d1  = 32'(tag) * 32'd3;
    u.d2  = $urandom;
    u.imm = 20'(tag);
    u.op  = 5'($urandom);
    u.fn  = 10'($urandom);
    return u;
  endfunction

  task automatic drive(input logic v, input logic rdy, input logic fl, input uop_t p);
    bus.valid   = v;
    bus.data1   = p.d1;
    bus.data2   = p.d2;
    bus.imm20   = p.imm;
    bus.opcode  = p.op;
    bus.funct   = p.fn;
    bus.itag    = p.tag;
    uop_ready_i = rdy;
    flush_i     = fl;
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input logic v, input logic rdy, input logic fl, input uop_t p);
    logic exp_v;
    logic take;
    logic push_ok;
    uop_t exp_h;
    @(negedge clk);
    drive(v, rdy, fl, p);
    #1;
    exp_v = (q.size() != 0);
    exp_h = (q.size() != 0) ? q[0] : p;
    take  = 1'b0;
`ifdef EXU_ISSUE_BYPASS_EN
    exp_v = exp_v | (v & !fl);
    take  = (q.size() == 0) && v && rdy && !fl;
`endif
    chk("full",  64'(bus.full),    64'(q.size() == DEPTH));
    chk("count", 64'(count_o),     64'(q.size()));
    chk("valid", 64'(uop_valid_o), 64'(exp_v));
    if (exp_v) begin
      chk("itag",  64'(uop_itag_o),   64'(exp_h.tag));
      chk("data1", 64'(uop_data1_o),  64'(exp_h.d1));
      chk("data2", 64'(uop_data2_o),  64'(exp_h.d2));
      chk("imm20", 64'(uop_imm20_o),  64'(exp_h.imm));
      chk("op",    64'(uop_opcode_o), 64'(exp_h.op));
      chk("funct", 64'(uop_funct_o),  64'(exp_h.fn));
    end
    if (fl) begin
      q.delete();
    end else begin
      push_ok = v && (q.size() < DEPTH) && !take;
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (push_ok) q.push_back(p);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && q.size() != 0; i++) cycle(1'b0, 1'b1, 1'b0, idle_uop);
    chk("drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    arst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, idle_uop);
    repeat (2) @(negedge clk);
    arst_i = 1'b0;
    #1;
    chk("rst_count", 64'(count_o),     64'd0);
    chk("rst_full",  64'(bus.full),    64'd0);
    chk("rst_valid", 64'(uop_valid_o), 64'd0);
    chk("rst_itag",  64'(uop_itag_o),  64'd0);

    // Fill to full, overflow push ignored, then drain in order.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, mk(8'(8'h11 + i)));
    cycle(1'b1, 1'b0, 1'b0, mk(8'h15));
    cycle(1'b1, 1'b1, 1'b0, mk(8'h15));
    drain();

    // Sustained streaming.
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, mk(8'(i)));
    drain();

    // Pointer wrap with random ready.
    begin
      int sent = 0;
      for (int i = 0; i < 60 && sent < 9; i++) begin
        logic acc;
        acc = (q.size() < DEPTH);
        cycle(1'b1, 1'($urandom), 1'b0, mk(8'(8'h20 + sent)));
        if (acc) sent++;
      end
      chk("wrap_sent", 64'(sent), 64'd9);
    end
    drain();

    // Flush at count 3 with simultaneous valid and ready.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, mk(8'(8'h30 + i)));
    cycle(1'b1, 1'b1, 1'b1, mk(8'h33));
    cycle(1'b0, 1'b0, 1'b0, idle_uop);
    cycle(1'b1, 1'b0, 1'b0, mk(8'h40));
    drain();

    // Asynchronous reset mid-cycle at count 2.
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, mk(8'(8'h50 + i)));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, idle_uop);
    #2 arst_i = 1'b1;
    #1;
    chk("arst_full",  64'(bus.full),    64'd0);
    chk("arst_valid", 64'(uop_valid_o), 64'd0);
    chk("arst_count", 64'(count_o),     64'd0);
    q.delete();
    @(negedge clk);
    arst_i = 1'b0;
    #1;
    chk("arst_itag", 64'(uop_itag_o), 64'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'($urandom), 1'b0, mk(8'(8'h60 + i)));
    drain();

`ifdef EXU_ISSUE_BYPASS_EN
    cycle(1'b1, 1'b1, 1'b0, mk(8'h7F));
    cycle(1'b1, 1'b0, 1'b0, mk(8'h7F));
    cycle(1'b0, 1'b0, 1'b0, idle_uop);
    drain();
`endif

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++)
      cycle(1'(($urandom % 4) != 0), 1'($urandom), 1'(($urandom % 32) == 0), mk(8'($urandom)));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/exu_issue_buffer.md
# exu_issue_buffer

Slave-side receiver for the pipeline-to-execution-unit issue port (the `alu_sif`/`lsu_sif` modport view: data1, data2, imm20, opcode, funct, itag, valid, full). It accepts issued micro-ops into a small in-order FIFO and asserts `full` as backpressure toward the issue stage. It presents the oldest entry to the execution unit core over a valid/ready handshake. One instance sits in front of each multi-cycle EXU (LSU, MDIV) so the issue stage is not stalled by a single busy cycle.

## Interface
- `DEPTH`, default 4: number of entries; power of two, ≥2.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `arst_i` input 1: asynchronous reset, active-high.
- `pip_exu_interface.lsu_sif` port `exu_sif`: issue-side slave view; inputs data1, data2, imm20, opcode, funct, itag, valid; output full.
- `flush_i` input 1: pipeline flush; discards all entries.
- `uop_valid_o` output 1: head entry valid toward the EXU core.
- `uop_ready_i` input 1: EXU core consumes head this cycle.
- `uop_data1_o` output `XLEN`: head data1.
- `uop_data2_o` output `XLEN`: head data2.
- `uop_imm20_o` output 20: head imm20.
- `uop_opcode_o` output 5: head opcode.
- `uop_funct_o` output 10: head funct.
- `uop_itag_o` output 8: head itag.
- `count_o` output $clog2(DEPTH+1): current occupancy, for performance counters.

## Operation
- Entry payload is {data1, data2, imm20, opcode, funct, itag}: 2·XLEN+43 bits, stored in a register array indexed by wr_ptr/rd_ptr.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. Occupancy is tracked in a separate counter.
- Push: `exu_sif.valid && !exu_sif.full && !flush_i`. The payload is written at wr_ptr, and wr_ptr increments.
- `valid` asserted while `full`=1 is ignored; no write occurs and nothing changes. The issue stage may hold valid high across full cycles.
- Pop: `uop_valid_o && uop_ready_i && !flush_i`. rd_ptr increments.
- Push and pop in the same cycle: count is unchanged. This is legal at count==DEPTH only if full was low that cycle, which never occurs, so no push happens when full.
- `full` = (count == DEPTH). It is combinational from registers only, with no path from `valid` or `uop_ready_i`.
- `uop_valid_o` = (count != 0).
- Head outputs are driven from array[rd_ptr]. When `uop_valid_o`=0 they are don't-care, but must not be X in simulation after reset.
- `flush_i` takes priority over push and pop. Next cycle: count=0, wr_ptr=rd_ptr=0, and the array contents are left unchanged.

## Timing
- Reset (async assert, sync release): count=0, both pointers 0, `full`=0, `uop_valid_o`=0, `count_o`=0. Array cleared to 0.
- Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- Registered path latency is 1 cycle: a uop pushed at edge N is visible on `uop_*_o` after edge N, with `uop_valid_o`=1.
- Throughput: one push and one pop per cycle sustained.
- `full` deasserts the cycle after a pop from a full buffer, so the issue stage sees a one-cycle bubble at most.
- `count_o` reflects the value after the last edge.

## Configuration
- `EXU_ISSUE_BYPASS_EN` defined:
  - When count==0, `exu_sif.valid`=1 and `uop_ready_i`=1, the incoming uop is forwarded combinationally to `uop_*_o` with `uop_valid_o`=1 and is not written.
  - This gives 0-cycle latency on an empty, ready buffer.
  - `uop_valid_o` = (count!=0) | (exu_sif.valid & !flush_i).
  - The head mux selects the incoming payload when count==0.
- `EXU_ISSUE_BYPASS_EN` undefined: purely registered behaviour as in Timing. There is no combinational path from `exu_sif` inputs to `uop_*_o`.

## Test plan
- Reset, then push itag 0x11,0x12,0x13,0x14 with `uop_ready_i`=0 (DEPTH=4):
  - `full`=1 after the 4th edge and `count_o`=4.
  - A 5th push of itag 0x15 is ignored.
  - Raise ready: pops appear in order 0x11..0x14, and 0x15 is never seen.
- Continuous push and pop with ready=1 for 20 cycles, itags 0..19:
  - count stays at 1 (registered build) or 0 (bypass build).
  - Output order is 0..19, with no bubbles after the first uop.
- Pointer wrap: push and pop 9 uops through DEPTH=4 with random ready. Output order and payload (data1=itag·3, imm20=itag) match.
- Flush at count=3 with simultaneous valid and ready:
  - Next cycle `uop_valid_o`=0, `count_o`=0, and the flushed-cycle uop is dropped.
  - Subsequent push of itag 0x40 emerges first.
- Assert `arst_i` asynchronously mid-cycle at count=2. `full`/`uop_valid_o` drop to 0 before the next edge, and the pointers are zero after release.
- Bypass build: empty buffer, valid=1 with itag 0x7F, ready=1. `uop_itag_o`=0x7F in the same cycle and `count_o` stays 0. With ready=0, the uop is stored and `count_o`=1.
